// File: rtl/segre_pkg.sv
// Shared parameters and types for the segre instruction-cache refill path.
package segre_pkg;

  localparam int unsigned ADDR_SIZE           = 32;
  localparam int unsigned ICACHE_LANE_SIZE    = 128;
  localparam int unsigned ICACHE_NUM_LANES    = 4;
  localparam int unsigned ICACHE_INDEX_SIZE   = 2;
  localparam int unsigned MEM_DATA_SIZE       = 32;
  localparam int unsigned ICACHE_REFILL_BEATS = ICACHE_LANE_SIZE / MEM_DATA_SIZE;
  localparam int unsigned REFILL_CNT_SIZE     = $clog2(ICACHE_REFILL_BEATS) + 1;
  localparam int unsigned LINE_OFFSET_SIZE    = $clog2(ICACHE_LANE_SIZE / 8);
  localparam int unsigned BEAT_BYTES          = MEM_DATA_SIZE / 8;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_FETCH,
    RF_FILL,
    RF_DRAIN
  } icache_refill_state_e;

  // Line-aligned base of a byte address.
  function automatic logic [ADDR_SIZE-1:0] line_base(input logic [ADDR_SIZE-1:0] addr);
    return {addr[ADDR_SIZE-1:LINE_OFFSET_SIZE], LINE_OFFSET_SIZE'(0)};
  endfunction

endpackage

// File: rtl/segre_icache_lru.sv
// True-LRU age tracker for the fully associative instruction cache.
module segre_icache_lru
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         touch_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] touch_idx_i,
  output logic [ICACHE_INDEX_SIZE-1:0] lru_idx_o
);

  logic [ICACHE_INDEX_SIZE-1:0] age [ICACHE_NUM_LANES];

  // Touched lane becomes age 0; lanes younger than it age by one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ICACHE_NUM_LANES; i++) begin
        age[i] <= ICACHE_INDEX_SIZE'(i);
      end
    end else if (touch_i) begin
      for (int unsigned i = 0; i < ICACHE_NUM_LANES; i++) begin
        if (ICACHE_INDEX_SIZE'(i) == touch_idx_i) begin
          age[i] <= '0;
        end else if (age[i] < age[touch_idx_i]) begin
          age[i] <= age[i] + ICACHE_INDEX_SIZE'(1);
        end
      end
    end
  end

  always_comb begin
    lru_idx_o = '0;
    for (int unsigned i = 0; i < ICACHE_NUM_LANES; i++) begin
      if (age[i] == ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1)) begin
        lru_idx_o = ICACHE_INDEX_SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/segre_icache_refill.sv
// Services IF-stage icache misses: fetches a line in beats, then pulses it back with an LRU victim lane.
module segre_icache_refill
  import segre_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ic_access_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  input  logic                         flush_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_req_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [MEM_DATA_SIZE-1:0]     mem_rdata_i,
  output logic                         busy_o
);

  localparam logic [REFILL_CNT_SIZE-1:0] BEATS = REFILL_CNT_SIZE'(ICACHE_REFILL_BEATS);

  icache_refill_state_e         state;
  logic [REFILL_CNT_SIZE-1:0]   issued;
  logic [REFILL_CNT_SIZE-1:0]   received;
  logic [REFILL_CNT_SIZE-1:0]   issued_nxt;
  logic [REFILL_CNT_SIZE-1:0]   received_nxt;
  logic [ADDR_SIZE-1:0]         base;
  logic [ICACHE_INDEX_SIZE-1:0] victim;
  logic [ICACHE_INDEX_SIZE-1:0] lru_idx;
  logic [ICACHE_INDEX_SIZE-1:0] touch_idx;
  logic [ICACHE_LANE_SIZE-1:0]  linebuf;
  logic [ICACHE_LANE_SIZE-1:0]  linebuf_nxt;
  logic                         touch;
  logic                         accept_miss;

  assign mem_req_o    = (state == RF_FETCH) && (issued < BEATS);
  assign mem_addr_o   = base + (ADDR_SIZE'(issued) * ADDR_SIZE'(BEAT_BYTES));
  assign busy_o       = (state != RF_IDLE);
  assign issued_nxt   = issued + REFILL_CNT_SIZE'(mem_req_o & mem_gnt_i);
  assign received_nxt = received + REFILL_CNT_SIZE'(mem_rvalid_i);
  assign accept_miss  = (state == RF_IDLE) && ic_access_i && ic_miss_i && !flush_i;

  // Hits and fills share the LRU port; they occur in different states.
  assign touch     = ((state == RF_IDLE) && ic_access_i && !ic_miss_i) || (state == RF_FILL);
  assign touch_idx = (state == RF_FILL) ? victim : ic_addr_i[ICACHE_INDEX_SIZE-1:0];

  segre_icache_lru u_lru (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .touch_i     (touch),
    .touch_idx_i (touch_idx),
    .lru_idx_o   (lru_idx)
  );

  always_comb begin
    linebuf_nxt = linebuf;
    for (int unsigned k = 0; k < ICACHE_REFILL_BEATS; k++) begin
      if (mem_rvalid_i && (received == REFILL_CNT_SIZE'(k))) begin
        linebuf_nxt[k*MEM_DATA_SIZE +: MEM_DATA_SIZE] = mem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= RF_IDLE;
      issued          <= '0;
      received        <= '0;
      base            <= '0;
      victim          <= ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1);
      linebuf         <= '0;
      mmu_data_o      <= 1'b0;
      mmu_wr_data_o   <= '0;
      mmu_lru_index_o <= ICACHE_INDEX_SIZE'(ICACHE_NUM_LANES - 1);
    end else begin
      mmu_data_o <= 1'b0;
      unique case (state)
        RF_IDLE: begin
          if (accept_miss) begin
            state           <= RF_FETCH;
            base            <= line_base(ic_addr_i);
            victim          <= lru_idx;
            mmu_lru_index_o <= lru_idx;
            issued          <= '0;
            received        <= '0;
          end
        end
        RF_FETCH: begin
          issued   <= issued_nxt;
          received <= received_nxt;
          linebuf  <= linebuf_nxt;
          // A grant in the flush cycle is already in flight and must be drained.
          if (flush_i) begin
            state <= (issued_nxt == received_nxt) ? RF_IDLE : RF_DRAIN;
          end else if (received_nxt == BEATS) begin
            state         <= RF_FILL;
            mmu_data_o    <= 1'b1;
            mmu_wr_data_o <= linebuf_nxt;
          end
        end
        RF_FILL: begin
          state <= RF_IDLE;
        end
        RF_DRAIN: begin
          received <= received_nxt;
          if (received_nxt == issued) begin
            state <= RF_IDLE;
          end
        end
        default: begin
          state <= RF_IDLE;
        end
      endcase
    end
  end

  rvalid_in_window: assert property (@(posedge clk_i) disable iff (rst_i)
    mem_rvalid_i |-> ((state == RF_FETCH) || (state == RF_DRAIN)));

endmodule
